// File: rtl/wb_merge.sv
// Writeback merge: gathers ALU results and memory read data onto one register-file
// write port in issue order, steered by a tag FIFO of {sel, rd} per dispatched op.
module wb_merge #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RD_W  = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    input  logic                     issue_sel_i,
    input  logic [RD_W-1:0]          issue_rd_i,
    output logic                     issue_ready_o,
    input  logic                     alu_valid_i,
    input  logic [WIDTH-1:0]         alu_data_i,
    output logic                     alu_ready_o,
    input  logic                     mem_valid_i,
    input  logic [WIDTH-1:0]         mem_data_i,
    output logic                     mem_ready_o,
    output logic                     wb_valid_o,
    output logic [WIDTH-1:0]         wb_data_o,
    output logic [RD_W-1:0]          wb_rd_o,
    output logic                     wb_sel_o,
    input  logic                     wb_ready_i,
    output logic [$clog2(DEPTH):0]   inflight_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic            tag_sel_q [DEPTH];
    logic [RD_W-1:0] tag_rd_q  [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
    logic             wb_sel_q, wb_sel_d;

    logic full, empty, out_free, head_sel, push, pop, alu_acc, mem_acc;

    always_comb begin
        full     = (count_q == CntW'(DEPTH));
        empty    = (count_q == '0);
        out_free = !wb_valid_q || wb_ready_i;
        head_sel = tag_sel_q[rd_ptr_q];
        // Readies depend only on FIFO head and output slot, never on source valids.
        alu_ready_o   = !empty && !head_sel && out_free;
        mem_ready_o   = !empty &&  head_sel && out_free;
        issue_ready_o = !full;
        alu_acc = alu_valid_i && alu_ready_o;
        mem_acc = mem_valid_i && mem_ready_o;
        pop     = alu_acc || mem_acc;
        push    = issue_valid_i && !full;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_sel_d   = wb_sel_q;
        if (pop) begin
            wb_valid_d = 1'b1;
            wb_data_d  = mem_acc ? mem_data_i : alu_data_i;
            wb_rd_d    = tag_rd_q[rd_ptr_q];
            wb_sel_d   = head_sel;
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_sel_q[i] <= 1'b0;
                tag_rd_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_sel_q   <= 1'b0;
        end else begin
            if (push) begin
                tag_sel_q[wr_ptr_q] <= issue_sel_i;
                tag_rd_q[wr_ptr_q]  <= issue_rd_i;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_sel_q   <= wb_sel_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_data_o  = wb_data_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_sel_o   = wb_sel_q;
    assign inflight_o = count_q;

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: ordering, reorder stall, full FIFO, backpressure,
// sustained throughput with pointer wrap, and asynchronous reset mid-burst.
module tb_wb_merge;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i, issue_sel_i;
    logic [4:0]  issue_rd_i;
    logic        issue_ready_o;
    logic        alu_valid_i, mem_valid_i;
    logic [31:0] alu_data_i, mem_data_i;
    logic        alu_ready_o, mem_ready_o;
    logic        wb_valid_o, wb_sel_o, wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic [2:0]  inflight_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    wb_merge #(.WIDTH(32), .DEPTH(4), .RD_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_sel_i(issue_sel_i), .issue_rd_i(issue_rd_i),
        .issue_ready_o(issue_ready_o),
        .alu_valid_i(alu_valid_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_sel_o(wb_sel_o),
        .wb_ready_i(wb_ready_i), .inflight_o(inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic sel, input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_sel_i   = sel;
        issue_rd_i    = rd;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] data,
                            input logic sel);
        check({tag, ".valid"}, wb_valid_o, 1'b1);
        check({tag, ".rd"}, wb_rd_o, rd);
        check({tag, ".data"}, wb_data_o, data);
        check({tag, ".sel"}, wb_sel_o, sel);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    int q[$];
    int issued, alu_done, mem_done, results, h;
    bit exp_alu, exp_mem, do_push;

    initial begin
        rst_ni = 1'b0;
        issue_valid_i = 0; issue_sel_i = 0; issue_rd_i = 0;
        alu_valid_i = 0; mem_valid_i = 0; alu_data_i = 0; mem_data_i = 0;
        wb_ready_i = 1'b1;
        #2;
        check("rst.issue_ready", issue_ready_o, 1'b1);
        check("rst.alu_ready", alu_ready_o, 1'b0);
        check("rst.mem_ready", mem_ready_o, 1'b0);
        check("rst.wb_valid", wb_valid_o, 1'b0);
        check("rst.wb_data", wb_data_o, 32'h0);
        check("rst.inflight", inflight_o, 3'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Stray source valids with an empty FIFO are ignored.
        alu_valid_i = 1; mem_valid_i = 1; alu_data_i = 32'hDEAD;
        #1;
        check("empty.alu_ready", alu_ready_o, 1'b0);
        check("empty.mem_ready", mem_ready_o, 1'b0);
        tick();
        check("empty.wb_valid", wb_valid_o, 1'b0);
        alu_valid_i = 0; mem_valid_i = 0;

        // In-order ALU then MEM.
        issue(1'b0, 5'd3);
        issue(1'b1, 5'd7);
        check("order.inflight", inflight_o, 3'd2);
        alu_valid_i = 1; alu_data_i = 32'h11;
        #1;
        check("order.alu_ready", alu_ready_o, 1'b1);
        check("order.mem_ready", mem_ready_o, 1'b0);
        tick();
        alu_valid_i = 0;
        check_wb("order.wb0", 5'd3, 32'h11, 1'b0);
        check("order.inflight1", inflight_o, 3'd1);
        mem_valid_i = 1; mem_data_i = 32'hAB;
        #1;
        check("order.mem_ready", mem_ready_o, 1'b1);
        tick();
        mem_valid_i = 0;
        check_wb("order.wb1", 5'd7, 32'hAB, 1'b1);
        check("order.inflight0", inflight_o, 3'd0);
        tick();
        check("order.wb_fall", wb_valid_o, 1'b0);
        check("order.wb_keep", wb_data_o, 32'hAB);

        // Reorder stall: ALU result waits behind MEM head.
        issue(1'b1, 5'd2);
        issue(1'b0, 5'd4);
        alu_valid_i = 1; alu_data_i = 32'h55;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall.alu_ready", alu_ready_o, 1'b0);
            tick();
            check("stall.wb_valid", wb_valid_o, 1'b0);
        end
        mem_valid_i = 1; mem_data_i = 32'h99;
        #1;
        check("stall.mem_ready", mem_ready_o, 1'b1);
        check("stall.alu_ready2", alu_ready_o, 1'b0);
        tick();
        mem_valid_i = 0;
        check_wb("stall.wb0", 5'd2, 32'h99, 1'b1);
        check("stall.alu_ready3", alu_ready_o, 1'b1);
        tick();
        alu_valid_i = 0;
        check_wb("stall.wb1", 5'd4, 32'h55, 1'b0);
        tick();

        // Full FIFO: 5th issue and a push coinciding with a pop are rejected.
        for (int i = 0; i < 4; i++) issue(1'b0, 5'(10 + i));
        check("full.issue_ready", issue_ready_o, 1'b0);
        check("full.inflight", inflight_o, 3'd4);
        issue(1'b0, 5'd14);
        check("full.inflight5", inflight_o, 3'd4);
        issue_valid_i = 1; issue_rd_i = 5'd15;
        alu_valid_i = 1; alu_data_i = 32'hA0;
        #1;
        check("full.pp_alu_ready", alu_ready_o, 1'b1);
        tick();
        issue_valid_i = 0;
        check("full.pp_inflight", inflight_o, 3'd3);
        check_wb("full.wb10", 5'd10, 32'hA0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_wb("full.wb13", 5'd13, 32'hA0, 1'b0);
        check("full.drained", inflight_o, 3'd0);
        check("full.no15", alu_ready_o, 1'b0);
        alu_valid_i = 0;
        tick();

        // Backpressure: held result stays stable, sources stalled.
        wb_ready_i = 0;
        issue(1'b0, 5'd5);
        issue(1'b0, 5'd6);
        alu_valid_i = 1; alu_data_i = 32'h77;
        tick();
        alu_data_i = 32'h88;
        for (int i = 0; i < 3; i++) begin
            check_wb("bp.hold", 5'd5, 32'h77, 1'b0);
            check("bp.alu_ready", alu_ready_o, 1'b0);
            check("bp.mem_ready", mem_ready_o, 1'b0);
            tick();
        end
        check("bp.inflight", inflight_o, 3'd1);
        wb_ready_i = 1;
        #1;
        check("bp.release_ready", alu_ready_o, 1'b1);
        tick();
        alu_valid_i = 0;
        check_wb("bp.next", 5'd6, 32'h88, 1'b0);
        tick();
        check("bp.fall", wb_valid_o, 1'b0);

        // Throughput and pointer wrap: 10 alternating ops, one result per cycle.
        issued = 0; alu_done = 0; mem_done = 0; results = 0;
        q.delete();
        for (int cyc = 0; cyc < 40 && !(issued == 10 && q.size() == 0); cyc++) begin
            issue_valid_i = (issued < 10);
            issue_sel_i   = issued[0];
            issue_rd_i    = 5'(issued + 1);
            alu_valid_i = 1; alu_data_i = 32'h100 + 32'(alu_done);
            mem_valid_i = 1; mem_data_i = 32'h200 + 32'(mem_done);
            exp_alu = (q.size() > 0) && (q[0] % 2 == 0);
            exp_mem = (q.size() > 0) && (q[0] % 2 == 1);
            do_push = (issued < 10) && (q.size() < 4);
            #1;
            check("tp.alu_ready", alu_ready_o, exp_alu);
            check("tp.mem_ready", mem_ready_o, exp_mem);
            tick();
            if (exp_alu || exp_mem) begin
                h = q.pop_front();
                check_wb("tp.wb", 5'(h + 1),
                         (h % 2 == 1) ? 32'h200 + 32'(h / 2) : 32'h100 + 32'(h / 2), h[0]);
                results++;
                if (h % 2 == 1) mem_done++; else alu_done++;
            end else begin
                check("tp.wb_idle", wb_valid_o, 1'b0);
            end
            if (do_push) begin
                q.push_back(issued);
                issued++;
            end
            check("tp.inflight", inflight_o, 3'(q.size()));
        end
        issue_valid_i = 0; alu_valid_i = 0; mem_valid_i = 0;
        check("tp.results", results, 10);
        tick();

        // Asynchronous reset mid-burst discards tags and the held result.
        issue(1'b0, 5'd20);
        issue(1'b1, 5'd21);
        issue(1'b0, 5'd22);
        alu_valid_i = 1; alu_data_i = 32'h33;
        tick();
        alu_valid_i = 0;
        check("mid.wb_valid_pre", wb_valid_o, 1'b1);
        #2;
        rst_ni = 0;
        #1;
        check("mid.issue_ready", issue_ready_o, 1'b1);
        check("mid.alu_ready", alu_ready_o, 1'b0);
        check("mid.mem_ready", mem_ready_o, 1'b0);
        check("mid.wb_valid", wb_valid_o, 1'b0);
        check("mid.wb_data", wb_data_o, 32'h0);
        check("mid.wb_rd", wb_rd_o, 5'd0);
        check("mid.wb_sel", wb_sel_o, 1'b0);
        check("mid.inflight", inflight_o, 3'd0);
        tick();
        rst_ni = 1;
        tick();
        issue(1'b0, 5'd9);
        alu_valid_i = 1; alu_data_i = 32'h5;
        tick();
        alu_valid_i = 0;
        check_wb("mid.after", 5'd9, 32'h5, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
